// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer write arbiter.
//   arb_state_e : arbiter states (IDLE, GRANT0, GRANT1)
//   RGB_W       : pixel colour width
//   CNT_W       : beat counter width
//   STAT_W      : width of the optional per-requester write counters
//   sat_inc     : saturating increment used by those counters
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int RGB_W  = 3;
  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v == STAT_MAX) begin
      r = v;
    end else begin
      r = v + STAT_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_write_arb_if.sv
// fb_write_arb_if: pixel requester and FIFO-write bundle for fb_write_arb.
//   enable               : global arbitration enable
//   rN_valid/last/hpos/vpos/RGB, rN_ready : two requester handshakes
//   fifofull             : FIFO almost-full (one entry still free)
//   wr_en, wr_hpos, wr_vpos, wr_RGB       : FIFO write port
// Modports: master = requesters + FIFO side, slave = arbiter.
interface fb_write_arb_if
  import fb_pkg::*;
#(
  parameter int X_WIRE_WIDTH = 11,
  parameter int Y_WIRE_WIDTH = 10
) ();

  logic                    enable;
  logic                    r0_valid;
  logic                    r0_last;
  logic [X_WIRE_WIDTH-1:0] r0_hpos;
  logic [Y_WIRE_WIDTH-1:0] r0_vpos;
  logic [RGB_W-1:0]        r0_RGB;
  logic                    r0_ready;
  logic                    r1_valid;
  logic                    r1_last;
  logic [X_WIRE_WIDTH-1:0] r1_hpos;
  logic [Y_WIRE_WIDTH-1:0] r1_vpos;
  logic [RGB_W-1:0]        r1_RGB;
  logic                    r1_ready;
  logic                    fifofull;
  logic                    wr_en;
  logic [X_WIRE_WIDTH-1:0] wr_hpos;
  logic [Y_WIRE_WIDTH-1:0] wr_vpos;
  logic [RGB_W-1:0]        wr_RGB;

  modport slave (
    input  enable,
    input  r0_valid, r0_last, r0_hpos, r0_vpos, r0_RGB,
    output r0_ready,
    input  r1_valid, r1_last, r1_hpos, r1_vpos, r1_RGB,
    output r1_ready,
    input  fifofull,
    output wr_en, wr_hpos, wr_vpos, wr_RGB
  );

  modport master (
    output enable,
    output r0_valid, r0_last, r0_hpos, r0_vpos, r0_RGB,
    input  r0_ready,
    output r1_valid, r1_last, r1_hpos, r1_vpos, r1_RGB,
    input  r1_ready,
    output fifofull,
    input  wr_en, wr_hpos, wr_vpos, wr_RGB
  );

endinterface

// File: rtl/fb_rr_pick.sv
// fb_rr_pick: two-way round-robin tie-break.
//   valid0, valid1 : requester valids
//   last_grant     : index of the requester that held the previous grant
//   winner         : index of the requester to grant next
// With only one valid that one wins; on a tie the requester that did not
// hold the previous grant wins.
module fb_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic winner
);

  // Winner selection
  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) begin
      winner = ~last_grant;
    end else if (valid1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/fb_write_arb.sv
// fb_write_arb: arbitrates two pixel requesters onto one frame-buffer
// write FIFO in bursts of up to BURST_LEN beats.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : fb_write_arb_if.slave (requesters, fifofull, FIFO write port)
//   wr_cnt0, wr_cnt1 : only with FBARB_STATS_EN defined; saturating
//                      counts of words written per requester
// A grant is released after the holder's last beat, after BURST_LEN beats,
// or as soon as the holder drops valid; every release passes through one
// IDLE cycle where the round-robin pick re-arbitrates.
module fb_write_arb
  import fb_pkg::*;
#(
  parameter int X_WIRE_WIDTH = 11,
  parameter int Y_WIRE_WIDTH = 10,
  parameter int BURST_LEN    = 16
) (
  input  logic               clk,
  input  logic               rst,
  fb_write_arb_if.slave      bus
`ifdef FBARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  wr_cnt0,
  output logic [STAT_W-1:0]  wr_cnt1
`endif
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  arb_state_e               state_r;
  arb_state_e               state_nx;
  logic                     last_grant_r;
  logic                     last_grant_nx;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_nx;
  logic                     pick_s;
  logic                     holder_s;
  logic                     holder_valid_s;
  logic                     holder_last_s;
  logic                     ready0_s;
  logic                     ready1_s;
  logic                     xfer_s;
  logic [X_WIRE_WIDTH-1:0]  sel_hpos_s;
  logic [Y_WIRE_WIDTH-1:0]  sel_vpos_s;
  logic [RGB_W-1:0]         sel_rgb_s;
  logic                     wr_en_r;
  logic [X_WIRE_WIDTH-1:0]  wr_hpos_r;
  logic [Y_WIRE_WIDTH-1:0]  wr_vpos_r;
  logic [RGB_W-1:0]         wr_rgb_r;

  fb_rr_pick u_pick (
    .valid0     (bus.r0_valid),
    .valid1     (bus.r1_valid),
    .last_grant (last_grant_r),
    .winner     (pick_s)
  );

  // Ready is gated by rst so both requesters see ready low during reset,
  // even in the first reset cycle before state has returned to IDLE.
  assign ready0_s = (state_r == GRANT0) & bus.enable & ~bus.fifofull & ~rst;
  assign ready1_s = (state_r == GRANT1) & bus.enable & ~bus.fifofull & ~rst;
  assign bus.r0_ready = ready0_s;
  assign bus.r1_ready = ready1_s;

  // Holder-side view: which requester owns the grant and its beat data
  always_comb begin
    holder_s       = 1'b0;
    holder_valid_s = 1'b0;
    holder_last_s  = 1'b0;
    sel_hpos_s     = bus.r0_hpos;
    sel_vpos_s     = bus.r0_vpos;
    sel_rgb_s      = bus.r0_RGB;
    xfer_s         = 1'b0;
    if (state_r == GRANT1) begin
      holder_s       = 1'b1;
      holder_valid_s = bus.r1_valid;
      holder_last_s  = bus.r1_last;
      sel_hpos_s     = bus.r1_hpos;
      sel_vpos_s     = bus.r1_vpos;
      sel_rgb_s      = bus.r1_RGB;
      xfer_s         = bus.r1_valid & ready1_s;
    end else begin
      holder_s       = 1'b0;
      holder_valid_s = bus.r0_valid;
      holder_last_s  = bus.r0_last;
      xfer_s         = bus.r0_valid & ready0_s;
    end
  end

  // Next-state, beat count and last-grant update
  always_comb begin
    state_nx      = state_r;
    count_nx      = count_r;
    last_grant_nx = last_grant_r;
    case (state_r)
      IDLE: begin
        if (bus.enable && (bus.r0_valid || bus.r1_valid)) begin
          state_nx = pick_s ? GRANT1 : GRANT0;
          count_nx = {CNT_W{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (!holder_valid_s) begin
          // Holder went quiet: give the other side a chance.
          state_nx      = IDLE;
          last_grant_nx = holder_s;
        end else if (xfer_s) begin
          count_nx = count_r + CNT_ONE;
          if (holder_last_s || (count_nx == BURST_MAX)) begin
            state_nx      = IDLE;
            last_grant_nx = holder_s;
          end else begin
            state_nx = state_r;
          end
        end else begin
          // Stalled by fifofull or enable low: keep grant and count.
          state_nx = state_r;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      count_r      <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nx;
      last_grant_r <= last_grant_nx;
      count_r      <= count_nx;
    end
  end

  // Registered FIFO write port; data holds when no write is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_r   <= 1'b0;
      wr_hpos_r <= {X_WIRE_WIDTH{1'b0}};
      wr_vpos_r <= {Y_WIRE_WIDTH{1'b0}};
      wr_rgb_r  <= {RGB_W{1'b0}};
    end else if (xfer_s) begin
      wr_en_r   <= 1'b1;
      wr_hpos_r <= sel_hpos_s;
      wr_vpos_r <= sel_vpos_s;
      wr_rgb_r  <= sel_rgb_s;
    end else begin
      wr_en_r <= 1'b0;
    end
  end

  assign bus.wr_en   = wr_en_r;
  assign bus.wr_hpos = wr_hpos_r;
  assign bus.wr_vpos = wr_vpos_r;
  assign bus.wr_RGB  = wr_rgb_r;

`ifdef FBARB_STATS_EN
  logic [STAT_W-1:0] cnt0_r;
  logic [STAT_W-1:0] cnt1_r;

  // Per-requester write counters, updated on the edge that raises wr_en
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {STAT_W{1'b0}};
      cnt1_r <= {STAT_W{1'b0}};
    end else if (xfer_s) begin
      if (holder_s) begin
        cnt1_r <= sat_inc(cnt1_r);
      end else begin
        cnt0_r <= sat_inc(cnt0_r);
      end
    end
  end

  assign wr_cnt0 = cnt0_r;
  assign wr_cnt1 = cnt1_r;
`endif

endmodule
